threshold_trigger_ctrl: RTL and testbench
=========================================

Name: threshold_trigger_ctrl

Overview:
Trigger controller that sequences a pair of unsigned magnitude comparisons, an arm threshold and a fire threshold, on a sample stream. It runs a hysteresis state machine (arm, then fire), emits a single-cycle trigger pulse, and enforces a programmable holdoff before re-arming. It sits between the ADC sample stream and the acquisition/DMA start logic. Thresholds and holdoff come from the config register bank.

Parameters:
DATA_WIDTH, 16, sample and threshold width; all compares unsigned.
HOLDOFF_WIDTH, 24, width of holdoff counter (clock cycles).
COUNT_WIDTH, 32, width of trigger event counter.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
enable  in  1  run control; low forces IDLE
rising  in  1  1 = rising-edge trigger, 0 = falling-edge trigger
arm_level  in  DATA_WIDTH  arm threshold
fire_level  in  DATA_WIDTH  fire threshold
holdoff  in  HOLDOFF_WIDTH  post-trigger dead time in clk cycles
din  in  DATA_WIDTH  sample
din_valid  in  1  sample qualifier
trigger  out  1  one-cycle pulse on fire
armed  out  1  high while in ARMED
holdoff_active  out  1  high while in HOLDOFF
trig_count  out  COUNT_WIDTH  number of triggers since reset

Behaviour:
- Clock is clk; reset is rst, synchronous, active-high. All outputs are registered.
- Reset values: state IDLE; trigger=0, armed=0, holdoff_active=0, trig_count=0, holdoff counter=0.
- Compare conditions are evaluated only on cycles with din_valid=1:
  - rising=1: arm_cond = din < arm_level; fire_cond = din >= fire_level.
  - rising=0: arm_cond = din > arm_level; fire_cond = din <= fire_level.
- rising, arm_level and fire_level are used live. No consistency check is made; if fire_level is on the wrong side of arm_level, behaviour follows the equations literally.
- States IDLE, ARMED, HOLDOFF (2-bit encoding).
  - IDLE: if enable and a valid sample has arm_cond -> ARMED at the next edge. One sample never both arms and fires.
  - ARMED: if enable and a valid sample has fire_cond -> trigger=1 for exactly the next cycle, trig_count+1 (wraps at max), and the holdoff value is latched into the counter.
    - Latched value 0 -> IDLE.
    - Otherwise -> HOLDOFF.
  - HOLDOFF: counter decrements every clk regardless of din_valid. When counter==1 -> IDLE at the next edge. Dead time is therefore exactly holdoff cycles after the trigger cycle. Samples are ignored.
- Latency: trigger asserts the cycle after the fire sample is presented. armed asserts the cycle after the arm sample is presented.
- enable=0 in any state -> IDLE at the next edge and the holdoff counter clears.
  - enable=0 on the same cycle as a fire sample: enable wins, no trigger, no count.
  - trig_count holds while disabled.
- A holdoff input change during HOLDOFF has no effect until the next trigger.
- rst mid-operation (any state, mid-holdoff) returns all state and outputs to reset values at the next edge. A pending trigger is dropped.
- din_valid=0 holds state in IDLE/ARMED. No X propagation from din when din_valid=0.

Decomposition:
- Shared package threshold_trigger_pkg: state typedef (IDLE=0, ARMED=1, HOLDOFF=2), edge-select constants RISING=1/FALLING=0.
- One sub-module, trig_compare_pair: purely combinational, produces arm_cond/fire_cond from din, thresholds and rising, using the existing comparator core semantics (LT/GE, GT/LE).
- FSM, holdoff counter and event counter live in the top module.

Test Plan:
- Rising, arm=100, fire=200, holdoff=0: samples 50,150,250 -> armed high after 50; trigger pulse 1 cycle after 250; trig_count=1; state IDLE.
- Falling, arm=200, fire=100: samples 250,150,90 -> trigger after 90. Rising with the same stream -> no trigger.
- Holdoff=5, rising sawtooth re-arming every cycle -> after a trigger, holdoff_active is high for exactly 5 cycles and no second trigger occurs before IDLE+arm+fire.
- din_valid=0 with din=0xFFFF while ARMED -> no trigger. Same value with din_valid=1 -> trigger.
- enable dropped on the fire-sample cycle -> no trigger, trig_count unchanged. enable dropped mid-HOLDOFF -> IDLE next cycle, holdoff_active=0.
- rst asserted during HOLDOFF and during ARMED -> all outputs 0 next cycle. Preload trig_count to max via repeated triggers (COUNT_WIDTH=4 build) -> wraps to 0.

Source files
------------

// File: rtl/threshold_trigger_pkg.sv
// threshold_trigger_pkg: shared state encoding and edge-select constants
package threshold_trigger_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, HOLDOFF = 2'd2} trig_state_t;
   localparam logic RISING = 1'b1;
   localparam logic FALLING = 1'b0;
endpackage

// File: rtl/trig_compare_pair.sv
// trig_compare_pair: unsigned arm/fire threshold compares for the selected edge
module trig_compare_pair
   import threshold_trigger_pkg::*;
#(
   parameter int DATA_WIDTH = 16
) (
   input  logic                  rising,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic [DATA_WIDTH-1:0] arm_level,
   input  logic [DATA_WIDTH-1:0] fire_level,
   output logic                  arm_cond,
   output logic                  fire_cond
);
   always_comb begin
      arm_cond  = (rising == RISING) ? (din < arm_level) : (din > arm_level);
      fire_cond = (rising == RISING) ? (din >= fire_level) : (din <= fire_level);
   end
endmodule

// File: rtl/threshold_trigger_ctrl.sv
// threshold_trigger_ctrl: arm/fire hysteresis trigger with holdoff and event count
module threshold_trigger_ctrl
   import threshold_trigger_pkg::*;
#(
   parameter int DATA_WIDTH    = 16,
   parameter int HOLDOFF_WIDTH = 24,
   parameter int COUNT_WIDTH   = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     enable,
   input  logic                     rising,
   input  logic [DATA_WIDTH-1:0]    arm_level,
   input  logic [DATA_WIDTH-1:0]    fire_level,
   input  logic [HOLDOFF_WIDTH-1:0] holdoff,
   input  logic [DATA_WIDTH-1:0]    din,
   input  logic                     din_valid,
   output logic                     trigger,
   output logic                     armed,
   output logic                     holdoff_active,
   output logic [COUNT_WIDTH-1:0]   trig_count
);
   trig_state_t state_q, state_d;
   logic [HOLDOFF_WIDTH-1:0] cnt_q, cnt_d;
   logic arm_cond, fire_cond, arm, fire;

   trig_compare_pair #(.DATA_WIDTH(DATA_WIDTH)) u_cmp (
      .rising    (rising),
      .din       (din),
      .arm_level (arm_level),
      .fire_level(fire_level),
      .arm_cond  (arm_cond),
      .fire_cond (fire_cond)
   );

   always_comb begin
      arm     = enable && din_valid && arm_cond && state_q == IDLE;
      fire    = enable && din_valid && fire_cond && state_q == ARMED;
      state_d = !enable                 ? IDLE :
                arm                     ? ARMED :
                fire                    ? (holdoff == '0 ? IDLE : HOLDOFF) :
                state_q == HOLDOFF      ? (cnt_q <= HOLDOFF_WIDTH'(1) ? IDLE : HOLDOFF) :
                state_q;
      cnt_d   = !enable                 ? '0 :
                fire                    ? holdoff :
                state_q == HOLDOFF      ? cnt_q - HOLDOFF_WIDTH'(1) :
                cnt_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         trigger        <= 1'b0;
         armed          <= 1'b0;
         holdoff_active <= 1'b0;
         trig_count     <= '0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         trigger        <= fire;
         armed          <= state_d == ARMED;
         holdoff_active <= state_d == HOLDOFF;
         if (fire) trig_count <= trig_count + COUNT_WIDTH'(1);
      end
   end
endmodule

// File: tb/tb_threshold_trigger_ctrl.sv
// tb_threshold_trigger_ctrl: directed vectors for threshold_trigger_ctrl (COUNT_WIDTH=4 build)
module tb_threshold_trigger_ctrl;
   logic clk = 1'b0, rst = 1'b1, enable = 1'b0, rising = 1'b1, din_valid = 1'b0;
   logic [15:0] arm_level = '0, fire_level = '0, din = '0;
   logic [23:0] holdoff = '0;
   logic trigger, armed, holdoff_active;
   logic [3:0] trig_count;
   int total = 0, passed = 0;

   threshold_trigger_ctrl #(.DATA_WIDTH(16), .HOLDOFF_WIDTH(24), .COUNT_WIDTH(4)) dut (
      .clk(clk), .rst(rst), .enable(enable), .rising(rising),
      .arm_level(arm_level), .fire_level(fire_level), .holdoff(holdoff),
      .din(din), .din_valid(din_valid), .trigger(trigger), .armed(armed),
      .holdoff_active(holdoff_active), .trig_count(trig_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else passed++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic outs(input string tag, input logic t, input logic a, input logic h, input logic [3:0] c);
      chk({tag, ".trigger"}, 32'(trigger), 32'(t));
      chk({tag, ".armed"}, 32'(armed), 32'(a));
      chk({tag, ".holdoff_active"}, 32'(holdoff_active), 32'(h));
      chk({tag, ".trig_count"}, 32'(trig_count), 32'(c));
   endtask

   task automatic sample(input logic [15:0] d);
      din = d;
      din_valid = 1'b1;
      tick();
   endtask

   initial begin
      tick();
      tick();
      outs("reset", 0, 0, 0, 0);
      rst = 1'b0;
      enable = 1'b1;
      rising = 1'b1; arm_level = 100; fire_level = 200; holdoff = 0;
      sample(50);  outs("r_arm", 0, 1, 0, 0);
      sample(150); outs("r_mid", 0, 1, 0, 0);
      sample(250); outs("r_fire", 1, 0, 0, 1);
      din_valid = 1'b0; tick(); outs("r_after", 0, 0, 0, 1);
      rising = 1'b0; arm_level = 200; fire_level = 100;
      sample(250); outs("f_arm", 0, 1, 0, 1);
      sample(150); outs("f_mid", 0, 1, 0, 1);
      sample(90);  outs("f_fire", 1, 0, 0, 2);
      din_valid = 1'b0; tick();
      rising = 1'b1;
      sample(250); outs("rs_250", 0, 0, 0, 2);
      sample(150); outs("rs_150", 0, 1, 0, 2);
      sample(90);  outs("rs_90", 0, 1, 0, 2);
      enable = 1'b0; tick(); outs("dis_armed", 0, 0, 0, 2);
      enable = 1'b1;
      arm_level = 100; fire_level = 200; holdoff = 5;
      sample(50);  outs("h_arm", 0, 1, 0, 2);
      sample(250); outs("h_fire", 1, 0, 1, 3);
      for (int i = 0; i < 4; i++) begin
         sample((i % 2) ? 16'd250 : 16'd50);
         outs("h_hold", 0, 0, 1, 3);
      end
      holdoff = 9;
      sample(250); outs("h_end", 0, 0, 0, 3);
      holdoff = 5;
      sample(50);  outs("h_rearm", 0, 1, 0, 3);
      sample(250); outs("h_fire2", 1, 0, 1, 4);
      sample(50);  outs("h_hold2", 0, 0, 1, 4);
      enable = 1'b0; tick(); outs("h_dis", 0, 0, 0, 4);
      enable = 1'b1; holdoff = 0;
      sample(50); outs("v_arm", 0, 1, 0, 4);
      din = 16'hFFFF; din_valid = 1'b0; tick(); outs("v_invalid", 0, 1, 0, 4);
      din_valid = 1'b1; tick(); outs("v_valid", 1, 0, 0, 5);
      din_valid = 1'b0; tick();
      sample(50); outs("e_arm", 0, 1, 0, 5);
      din = 250; enable = 1'b0; tick(); outs("e_drop_fire", 0, 0, 0, 5);
      enable = 1'b1; holdoff = 5;
      sample(50);  sample(250); outs("rh_fire", 1, 0, 1, 6);
      rst = 1'b1; tick(); outs("rst_hold", 0, 0, 0, 0);
      rst = 1'b0;
      sample(50); outs("ra_arm", 0, 1, 0, 0);
      din = 250; rst = 1'b1; tick(); outs("rst_armed", 0, 0, 0, 0);
      rst = 1'b0; holdoff = 0;
      for (int i = 1; i <= 16; i++) begin
         sample(50);
         sample(250);
         chk("wrap_count", 32'(trig_count), 32'(i % 16));
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
